// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM encoding,
// prefix byte values and the frame check helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic ps2_frame_ok(input logic [7:0] data,
                                        input logic       parity,
                                        input logic       stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 lines plus falling-edge detect on
// the synchronised clock. Flops reset to 1 so the idle bus never looks like an edge.
module ps2_sync_edge (
  input  logic CLK,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_edge
);

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;

  // Synchroniser chains and one-cycle-delayed copy of the synced clock.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  assign data_sync = data_sync_r;
  assign fall_edge = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks parity/stop,
// folds E0/F0 prefixes into flags and strobes out completed scan codes.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] oCode,
  output logic       oBreak,
  output logic       oExt,
  output logic       oValid,
  output logic       oErr
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] tmo_r;
  logic          brk_pending_r;
  logic          ext_pending_r;
  logic          data_sync_s;
  logic          fall_edge_s;

  ps2_sync_edge u_sync (
    .CLK       (CLK),
    .reset     (reset),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .data_sync (data_sync_s),
    .fall_edge (fall_edge_s)
  );

  // Frame FSM, shift register, timeout, prefix tracking and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_r      <= 1'b0;
      tmo_r         <= '0;
      brk_pending_r <= 1'b0;
      ext_pending_r <= 1'b0;
      oCode         <= 8'h00;
      oBreak        <= 1'b0;
      oExt          <= 1'b0;
      oValid        <= 1'b0;
      oErr          <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oErr   <= 1'b0;
      // An edge always beats a timeout arriving in the same cycle.
      if (fall_edge_s) begin
        tmo_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!data_sync_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_sync_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_r <= data_sync_s;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (!ps2_frame_ok(shift_r, parity_r, data_sync_s)) begin
              oErr          <= 1'b1;
              brk_pending_r <= 1'b0;
              ext_pending_r <= 1'b0;
            end else if (shift_r == PS2_PFX_EXT) begin
              ext_pending_r <= 1'b1;
            end else if (shift_r == PS2_PFX_BRK) begin
              brk_pending_r <= 1'b1;
            end else begin
              oCode         <= shift_r;
              oBreak        <= brk_pending_r;
              oExt          <= ext_pending_r;
              oValid        <= 1'b1;
              brk_pending_r <= 1'b0;
              ext_pending_r <= 1'b0;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r == ST_IDLE) begin
        tmo_r <= '0;
      end else if (tmo_r >= TMO_LAST) begin
        // Abort at the limit, so the counter can never wrap.
        state_r       <= ST_IDLE;
        tmo_r         <= '0;
        oErr          <= 1'b1;
        brk_pending_r <= 1'b0;
        ext_pending_r <= 1'b0;
      end else begin
        tmo_r <= tmo_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised bench for ps2_scancode_rx: drives PS/2 frames and compares
// strobes and outputs against a frame-level model of the protocol.
module tb_ps2_scancode_rx;

  localparam int TMO = 100;

  logic       CLK = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] oCode;
  logic       oBreak;
  logic       oExt;
  logic       oValid;
  logic       oErr;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .oCode    (oCode),
    .oBreak   (oBreak),
    .oExt     (oExt),
    .oValid   (oValid),
    .oErr     (oErr)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  // Model: visible outputs and pending prefix flags.
  logic [7:0] mo_code = 8'h00;
  logic       mo_brk = 1'b0;
  logic       mo_ext = 1'b0;
  logic       mp_brk = 1'b0;
  logic       mp_ext = 1'b0;

  always @(negedge CLK) begin
    if (oValid) n_valid++;
    if (oErr) n_err++;
    if (oValid && oErr) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit good_parity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic send_bit(input bit b, input int h);
    @(negedge CLK);
    PS2_DATA = b;
    repeat (h) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (h) @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/code"}, 32'(oCode), 32'(mo_code));
    check({tag, "/brk"}, 32'(oBreak), 32'(mo_brk));
    check({tag, "/ext"}, 32'(oExt), 32'(mo_ext));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stp, input string tag);
    int v0, e0, h;
    bit good;
    int exp_v, exp_e;
    v0 = n_valid;
    e0 = n_err;
    h = $urandom_range(3, 8);
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++) send_bit(b[i], h);
    send_bit(par, h);
    send_bit(stp, h);
    repeat (6) @(posedge CLK);
    #1;
    good = ((($countones(b) + int'(par)) % 2) == 1) && stp;
    exp_v = 0;
    exp_e = 0;
    if (!good) begin
      exp_e = 1;
      mp_brk = 1'b0;
      mp_ext = 1'b0;
    end else if (b == 8'hE0) begin
      mp_ext = 1'b1;
    end else if (b == 8'hF0) begin
      mp_brk = 1'b1;
    end else begin
      exp_v = 1;
      mo_code = b;
      mo_brk = mp_brk;
      mo_ext = mp_ext;
      mp_brk = 1'b0;
      mp_ext = 1'b0;
    end
    check({tag, "/valid"}, 32'(n_valid - v0), 32'(exp_v));
    check({tag, "/err"}, 32'(n_err - e0), 32'(exp_e));
    check_outputs(tag);
  endtask

  task automatic good_frame(input logic [7:0] b, input string tag);
    send_frame(b, good_parity(b), 1'b1, tag);
  endtask

  initial begin
    int v0, e0, first;
    logic [7:0] b;
    bit par, stp;
    logic [7:0] partial;
    reset = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    repeat (4) @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("rst/valid", 32'(oValid), 32'd0);
    check("rst/err", 32'(oErr), 32'd0);
    check_outputs("rst");

    good_frame(8'h16, "f16");
    good_frame(8'hF0, "brk_pfx");
    good_frame(8'h1E, "brk_1e");
    good_frame(8'hE0, "ext_pfx");
    good_frame(8'hF0, "ext_brk_pfx");
    good_frame(8'h5A, "ext_brk_5a");
    good_frame(8'h45, "plain_45");
    send_frame(8'h16, ~good_parity(8'h16), 1'b1, "bad_par");
    good_frame(8'hF0, "brk_pfx2");
    send_frame(8'h33, ~good_parity(8'h33), 1'b1, "bad_par2");
    good_frame(8'h26, "after_bad");
    send_frame(8'h29, good_parity(8'h29), 1'b0, "bad_stop");

    // Partial frame then silence: expect a timeout abort.
    good_frame(8'hE0, "to_pfx");
    v0 = n_valid;
    e0 = n_err;
    partial = 8'hA5;
    send_bit(1'b0, 5);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 5);
    first = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      #1;
      if (oErr && first < 0) first = i + 6;
    end
    mp_brk = 1'b0;
    mp_ext = 1'b0;
    check("to/err_cnt", 32'(n_err - e0), 32'd1);
    check("to/valid", 32'(n_valid - v0), 32'd0);
    check("to/latency_ok", 32'((first >= 98) && (first <= 106)), 32'd1);
    good_frame(8'h26, "to_26");

    // Reset mid-frame discards it and clears everything.
    good_frame(8'hF0, "rs_pfx");
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0, 4);
    for (int i = 0; i < 5; i++) send_bit(partial[i], 4);
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    mo_code = 8'h00;
    mo_brk = 1'b0;
    mo_ext = 1'b0;
    mp_brk = 1'b0;
    mp_ext = 1'b0;
    check("rs/valid", 32'(n_valid - v0), 32'd0);
    check("rs/err", 32'(n_err - e0), 32'd0);
    check_outputs("rs");
    good_frame(8'h3D, "rs_3d");

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      par = good_parity(b);
      if ($urandom_range(0, 7) == 0) par = ~par;
      stp = ($urandom_range(0, 15) != 0);
      send_frame(b, par, stp, $sformatf("rnd%0d", k));
    end

    check("no_overlap", 32'(n_both), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
